systolic_array_os_param: RTL
============================

// Module: systolic_array_os_param
// PURPOSE
//  Parametrised output-stationary ROWS x COLS MAC systolic array; generalises the fixed 4x4 array.
//  Computes C = A*B over a K-beat reduction, A streamed from west, B from north.
//  Input skew is applied internally; caller presents unskewed vectors.
//  Results drain one row per valid/ready handshake to the downstream writeback/requant stage.
// PARAMETERS
//  DATA_WIDTH  8    operand width (A, B elements)
//  ACC_WIDTH   24   per-PE accumulator width, also result width
//  ROWS        4    PE rows = west lanes = drained rows (>=1)
//  COLS        4    PE cols = north lanes = elements per output beat (>=1)
//  K_MAX       256  max reduction length; KW = $clog2(K_MAX+1)
// PORTS
//  clk          in   1                 clock, rising edge
//  rst_n        in   1                 asynchronous, active-low reset
//  start        in   1                 launch job; sampled only in IDLE
//  k_len        in   KW                reduction length, sampled with start (0..K_MAX)
//  signed_mode  in   1                 1: signed two's-complement operands; sampled with start
//  in_valid     in   1                 west_data/north_data beat valid
//  in_ready     out  1                 array accepts a beat
//  west_data    in   ROWS*DATA_WIDTH   lane r = A[r][k], lane 0 in LSBs
//  north_data   in   COLS*DATA_WIDTH   lane c = B[k][c], lane 0 in LSBs
//  out_valid    out  1                 out_data/out_row valid
//  out_ready    in   1                 downstream accepts result row
//  out_data     out  COLS*ACC_WIDTH    C[out_row][c], lane 0 in LSBs
//  out_row      out  max(1,$clog2(ROWS)) index of current result row
//  busy         out  1                 high in any state except IDLE
//  done         out  1                 one-cycle pulse after last row accepted
// BEHAVIOUR
//  Reset: FSM=IDLE; in_ready, out_valid, busy, done = 0; out_data, out_row = 0; all PE acc/regs = 0.
//  FSM: IDLE -> LOAD -> FLUSH -> DRAIN -> IDLE.
//   IDLE: start=1 clears every accumulator and pipeline reg, latches k_len, signed_mode;
//         next state LOAD if k_len!=0, else DRAIN (drains all-zero results). start ignored otherwise.
//   LOAD: in_ready=1. Beat accepted on in_valid&&in_ready; array advances ONLY on an accepted beat
//         (global enable), so in_valid bubbles insert no zeros and keep skew exact.
//         After k_len-th accepted beat -> FLUSH; in_ready drops the following cycle.
//   FLUSH: array advances every cycle with zero operands for exactly ROWS+COLS-1 cycles -> DRAIN.
//   DRAIN: rows emitted in order 0..ROWS-1; out_valid rises first DRAIN cycle.
//         out_data/out_row held stable while out_valid && !out_ready. On handshake, next row
//         presented the next cycle (no bubble). After row ROWS-1 handshake: done=1 for 1 cycle, -> IDLE.
//  Skew: west lane r delayed r beats, north lane c delayed c beats (enable-gated shift registers).
//  PE(r,c): registers a east, b south (one stage each); acc <= acc + a*b when enabled.
//   Product 2*DATA_WIDTH bits, sign- or zero-extended per signed_mode to ACC_WIDTH;
//   accumulation wraps modulo 2^ACC_WIDTH, no saturation, no overflow flag.
//  Result read: accumulators frozen in DRAIN; out_data = acc row selected by out_row (mux, registered).
//  k_len > K_MAX: clamp to K_MAX.
//  rst_n low in any state: immediate return to reset values, partial results discarded.
// TESTING
//  T1 4x4 default, unsigned, k_len=4, A=I, B[k][c]=4k+c+1 -> rows 0..3 = B rows; done 1 pulse.
//  T2 signed_mode=1, k_len=3, all A=-1(0xFF), all B=-1 -> every C=3; signed_mode=0 same data -> 3*65025=195075.
//  T3 in_valid random 50% bubbles, k_len=16, random A/B -> results bit-match golden model (no bubble corruption).
//  T4 out_ready low 5 cycles on row 1 -> out_valid high, out_data/out_row=1 stable; rows delivered once, in order.
//  T5 ACC_WIDTH=16, unsigned, k_len=2, A=B=0xFF -> C=130050 mod 65536=64514 (wrap).
//  T6 k_len=0 -> straight to DRAIN, 4 zero rows; rst_n low mid-LOAD -> outputs 0, IDLE; new job correct.

Source files
------------

// File: rtl/systolic_array_os_param.sv
// systolic_array_os_param
// Output-stationary ROWS x COLS multiply-accumulate systolic array.
// A job computes C = A*B over k_len beats: row r of A enters from the west,
// column c of B enters from the north, and each PE(r,c) keeps C[r][c] in place.
// The caller presents unskewed beats; the diagonal skew is applied inside.
// Results drain one row per valid/ready handshake.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             launch a job (only honoured in IDLE)
//   k_len             reduction length, clamped to K_MAX, latched with start
//   signed_mode       1 = signed two's-complement operands, latched with start
//   in_valid/in_ready operand beat handshake (west_data, north_data)
//   west_data         lane r = A[r][k], lane 0 in LSBs
//   north_data        lane c = B[k][c], lane 0 in LSBs
//   out_valid/out_ready  result row handshake
//   out_data          C[out_row][c], lane 0 in LSBs
//   out_row           index of the row on out_data
//   busy              high whenever a job is in progress
//   done              one-cycle pulse after the last row is accepted

module systolic_array_os_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int K_MAX      = 256,
  localparam int KW        = $clog2(K_MAX + 1),
  localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [KW-1:0]             k_len,
  input  logic                      signed_mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] west_data,
  input  logic [COLS*DATA_WIDTH-1:0] north_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [COLS*ACC_WIDTH-1:0] out_data,
  output logic [RW-1:0]             out_row,
  output logic                      busy,
  output logic                      done
);

  // Multiplier width: wide enough that truncating to ACC_WIDTH gives the
  // correctly wrapped, correctly extended product in both modes.
  localparam int EW = (ACC_WIDTH > 2 * DATA_WIDTH) ? ACC_WIDTH : 2 * DATA_WIDTH;
  localparam int FW = $clog2(ROWS + COLS);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(ROWS + COLS - 2);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [KW-1:0]            k_len_q, k_len_d;
  logic [KW-1:0]            beat_cnt_q, beat_cnt_d;
  logic [FW-1:0]            flush_cnt_q, flush_cnt_d;
  logic                     signed_q, signed_d;
  logic                     out_valid_q, out_valid_d;
  logic [RW-1:0]            out_row_q, out_row_d;
  logic [COLS*ACC_WIDTH-1:0] out_data_q, out_data_d;
  logic                     done_q, done_d;

  logic                     clr;
  logic                     adv;
  logic [RW-1:0]            row_nxt;
  logic [COLS*ACC_WIDTH-1:0] row0_data;
  logic [COLS*ACC_WIDTH-1:0] nxt_data;

  logic [DATA_WIDTH-1:0]    west_in  [ROWS];
  logic [DATA_WIDTH-1:0]    north_in [COLS];
  logic [DATA_WIDTH-1:0]    west_sk  [ROWS];
  logic [DATA_WIDTH-1:0]    north_sk [COLS];
  logic [DATA_WIDTH-1:0]    a_pe     [ROWS][COLS];
  logic [DATA_WIDTH-1:0]    b_pe     [ROWS][COLS];
  logic [ACC_WIDTH-1:0]     acc_pe   [ROWS][COLS];

  // Operands are extended to EW bits per mode; low bits of the product are
  // the same for signed and unsigned interpretation, so one multiplier serves both.
  function automatic logic [ACC_WIDTH-1:0] mac_prod(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b,
                                                   input logic                  sm);
    logic [EW-1:0] ax;
    logic [EW-1:0] bx;
    ax = {{(EW - DATA_WIDTH){sm & a[DATA_WIDTH-1]}}, a};
    bx = {{(EW - DATA_WIDTH){sm & b[DATA_WIDTH-1]}}, b};
    return ACC_WIDTH'(ax * bx);
  endfunction

  // Edge operands: live data while loading, zeros while flushing the pipeline
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      west_in[r] = (state_q == S_FLUSH) ? '0 : west_data[r*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int c = 0; c < COLS; c++) begin
      north_in[c] = (state_q == S_FLUSH) ? '0 : north_data[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // West skew: lane r is delayed r enabled steps so A[r][k] meets B[k][c] at PE(r,c)
  for (genvar r = 0; r < ROWS; r++) begin : g_west
    if (r == 0) begin : g_pass
      assign west_sk[r] = west_in[r];
    end else begin : g_dly
      logic [DATA_WIDTH-1:0] sh_q [r];
      logic [DATA_WIDTH-1:0] sh_d [r];
      always_comb begin
        for (int i = 0; i < r; i++) sh_d[i] = sh_q[i];
        if (clr) begin
          for (int i = 0; i < r; i++) sh_d[i] = '0;
        end else if (adv) begin
          sh_d[0] = west_in[r];
          for (int i = 1; i < r; i++) sh_d[i] = sh_q[i-1];
        end
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < r; i++) sh_q[i] <= '0;
        end else begin
          for (int i = 0; i < r; i++) sh_q[i] <= sh_d[i];
        end
      end
      assign west_sk[r] = sh_q[r-1];
    end
  end

  // North skew: lane c is delayed c enabled steps
  for (genvar c = 0; c < COLS; c++) begin : g_north
    if (c == 0) begin : g_pass
      assign north_sk[c] = north_in[c];
    end else begin : g_dly
      logic [DATA_WIDTH-1:0] sh_q [c];
      logic [DATA_WIDTH-1:0] sh_d [c];
      always_comb begin
        for (int i = 0; i < c; i++) sh_d[i] = sh_q[i];
        if (clr) begin
          for (int i = 0; i < c; i++) sh_d[i] = '0;
        end else if (adv) begin
          sh_d[0] = north_in[c];
          for (int i = 1; i < c; i++) sh_d[i] = sh_q[i-1];
        end
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < c; i++) sh_q[i] <= '0;
        end else begin
          for (int i = 0; i < c; i++) sh_q[i] <= sh_d[i];
        end
      end
      assign north_sk[c] = sh_q[c-1];
    end
  end

  // PE grid: forward a east and b south one stage each, accumulate in place
  for (genvar r = 0; r < ROWS; r++) begin : g_pe_row
    for (genvar c = 0; c < COLS; c++) begin : g_pe_col
      logic [DATA_WIDTH-1:0] a_src, b_src;
      logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
      logic [ACC_WIDTH-1:0]  acc_q, acc_d;

      if (c == 0) begin : g_a_edge
        assign a_src = west_sk[r];
      end else begin : g_a_int
        assign a_src = a_pe[r][c-1];
      end
      if (r == 0) begin : g_b_edge
        assign b_src = north_sk[c];
      end else begin : g_b_int
        assign b_src = b_pe[r-1][c];
      end

      always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        if (clr) begin
          a_d   = '0;
          b_d   = '0;
          acc_d = '0;
        end else if (adv) begin
          a_d   = a_src;
          b_d   = b_src;
          acc_d = acc_q + mac_prod(a_src, b_src, signed_q);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q   <= '0;
          b_q   <= '0;
          acc_q <= '0;
        end else begin
          a_q   <= a_d;
          b_q   <= b_d;
          acc_q <= acc_d;
        end
      end

      assign a_pe[r][c]   = a_q;
      assign b_pe[r][c]   = b_q;
      assign acc_pe[r][c] = acc_q;
    end
  end

  // Result row mux: row 0 on DRAIN entry, the following row on each handshake
  always_comb begin
    row_nxt = out_row_q + RW'(1);
    for (int c = 0; c < COLS; c++) begin
      row0_data[c*ACC_WIDTH +: ACC_WIDTH] = acc_pe[0][c];
      nxt_data[c*ACC_WIDTH +: ACC_WIDTH]  = acc_pe[row_nxt][c];
    end
  end

  // Control FSM; the array only advances on accepted beats or flush cycles,
  // so input bubbles never disturb the skew alignment
  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    signed_d    = signed_q;
    beat_cnt_d  = beat_cnt_q;
    flush_cnt_d = flush_cnt_q;
    out_valid_d = out_valid_q;
    out_row_d   = out_row_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    clr         = 1'b0;
    adv         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          clr         = 1'b1;
          k_len_d     = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
          signed_d    = signed_mode;
          beat_cnt_d  = '0;
          flush_cnt_d = '0;
          if (k_len == '0) begin
            state_d     = S_DRAIN;
            out_valid_d = 1'b1;
            out_row_d   = '0;
            out_data_d  = '0;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          adv        = 1'b1;
          beat_cnt_d = beat_cnt_q + KW'(1);
          if (beat_cnt_d == k_len_q) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        adv         = 1'b1;
        flush_cnt_d = flush_cnt_q + FW'(1);
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d     = S_DRAIN;
          out_valid_d = 1'b1;
          out_row_d   = '0;
          out_data_d  = row0_data;
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (out_row_q == RW'(ROWS - 1)) begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = S_IDLE;
          end else begin
            out_row_d  = row_nxt;
            out_data_d = nxt_data;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_len_q     <= '0;
      signed_q    <= 1'b0;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      signed_q    <= signed_d;
      beat_cnt_q  <= beat_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      out_valid_q <= out_valid_d;
      out_row_q   <= out_row_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = (state_q == S_LOAD);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_row   = out_row_q;
  assign out_data  = out_data_q;
  assign done      = done_q;

endmodule
